// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline hazard/fetch control bundle between datapath and pipe_ctrl
interface pipe_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_redirect;
    logic              ex_busy;
    logic              imem_valid;
    logic              halt_req;
    logic              resume;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              halted;
    logic              imem_err;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_mem_read, ex_rd,
               ex_redirect, ex_busy, imem_valid, halt_req, resume,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, halted, imem_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_mem_read, ex_rd,
               ex_redirect, ex_busy, imem_valid, halt_req, resume,
        output pc_en, ifid_en, ifid_flush, idex_bubble, halted, imem_err
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - in-order pipeline stall/flush/halt controller with fetch timeout
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              load_use;
    logic              pc_en, ifid_en, ifid_flush, idex_bubble, halted;
    logic [CW-1:0]     wait_cnt;
    logic              imem_err;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    // x0 is hardwired, so a load targeting it never creates a hazard
    assign load_use = bus.ex_mem_read && (rd != '0) &&
                      ((bus.id_use1 && (rs1 == rd)) || (bus.id_use2 && (rs2 == rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        case (state)
            RUN: begin
                if (bus.ex_redirect) begin
                    pc_en       = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (!bus.imem_valid) state_next = DRAIN;
                end else if (bus.ex_busy) begin
                    pc_en = 1'b0;
                end else if (load_use) begin
                    idex_bubble = 1'b1;
                end else if (!bus.imem_valid) begin
                    ifid_flush = 1'b1;
                end else if (bus.halt_req) begin
                    idex_bubble = 1'b1;
                    state_next  = HALT;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            DRAIN: begin
                // the response in flight belongs to the squashed path; drop it
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (bus.imem_valid) begin
                    pc_en      = 1'b1;
                    state_next = RUN;
                end
            end
            HALT: begin
                idex_bubble = 1'b1;
                halted      = 1'b1;
                if (bus.resume && !bus.halt_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (ifid_flush) ifid_en = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            imem_err <= 1'b0;
        end else begin
            if (bus.imem_valid) begin
                wait_cnt <= '0;
            end else if ((state != HALT) && (wait_cnt != CW'(TIMEOUT))) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // set on the same edge the counter reaches TIMEOUT
            if (!bus.imem_valid && (state != HALT) && (wait_cnt == CW'(TIMEOUT - 1))) begin
                imem_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state == RUN) && !pc_en) stall_cnt <= stall_cnt + 32'd1;
            if ((state == RUN) && bus.ex_redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.halted      = halted;
    assign bus.imem_err    = imem_err;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] ctl;

    pipe_ctrl_if #(.REG_AW(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl #(.REG_AW(5), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {pc_en, ifid_en, ifid_flush, idex_bubble}
    assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use1 = 0; bus.id_use2 = 0;
        bus.ex_mem_read = 0; bus.ex_rd = '0; bus.ex_redirect = 0; bus.ex_busy = 0;
        bus.imem_valid = 1; bus.halt_req = 0; bus.resume = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL reset_ctl got=%b exp=0011", ctl); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.imem_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.imem_err); end
        tick();
        rst_n = 1;
        tick();
        checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL run_idle got=%b exp=1100", ctl); end
    endtask

    task automatic test_load_use();
        bus.ex_mem_read = 1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use1 = 1;
        #1;
        checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL load_use got=%b exp=0001", ctl); end
        tick();
        bus.ex_mem_read = 0;
        #1;
        checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL load_use_after got=%b exp=1100", ctl); end
        bus.ex_mem_read = 1; bus.id_use1 = 0; bus.id_rs2 = 5'd5; bus.id_use2 = 1;
        #1;
        checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL load_use_rs2 got=%b exp=0001", ctl); end
        bus.id_use2 = 0;
        #1;
        checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL load_use_unused got=%b exp=1100", ctl); end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        bus.ex_mem_read = 1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use1 = 1;
        #1;
        checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL x0_no_stall got=%b exp=1100", ctl); end
        idle_inputs();
        tick();
    endtask

    task automatic test_redirect_pending();
        bus.ex_redirect = 1; bus.imem_valid = 0;
        #1;
        checks++; if (ctl !== 4'b1011) begin errors++; $display("FAIL redir_c1 got=%b exp=1011", ctl); end
        tick();
        bus.ex_redirect = 0;
        #1;
        checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL redir_c2 got=%b exp=0011", ctl); end
        tick();
        #1;
        checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL redir_c3 got=%b exp=0011", ctl); end
        tick();
        bus.imem_valid = 1;
        #1;
        checks++; if (ctl !== 4'b1011) begin errors++; $display("FAIL redir_c4 got=%b exp=1011", ctl); end
        tick();
        checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL redir_back_run got=%b exp=1100", ctl); end
    endtask

    task automatic test_priority();
        bus.ex_redirect = 1; bus.ex_busy = 1;
        bus.ex_mem_read = 1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_use1 = 1;
        #1;
        checks++; if (ctl !== 4'b1011) begin errors++; $display("FAIL prio_redirect got=%b exp=1011", ctl); end
        bus.ex_redirect = 0;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL prio_busy got=%b exp=0000", ctl); end
        bus.ex_busy = 0; bus.imem_valid = 0;
        #1;
        checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL prio_loaduse got=%b exp=0001", ctl); end
        bus.ex_mem_read = 0;
        #1;
        checks++; if (ctl !== 4'b0010) begin errors++; $display("FAIL fetch_miss got=%b exp=0010", ctl); end
        idle_inputs();
        tick();
        checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL prio_stay_run got=%b exp=1100", ctl); end
    endtask

    task automatic test_timeout();
        bus.imem_valid = 0;
        repeat (15) tick();
        checks++; if (bus.imem_err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", bus.imem_err); end
        tick();
        checks++; if (bus.imem_err !== 1'b1) begin errors++; $display("FAIL timeout_set got=%b exp=1", bus.imem_err); end
        bus.imem_valid = 1;
        tick();
        tick();
        checks++; if (bus.imem_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", bus.imem_err); end
    endtask

    task automatic test_halt_reset();
        bus.halt_req = 1;
        #1;
        checks++; if (ctl !== 4'b0001 || bus.halted !== 1'b0) begin errors++; $display("FAIL halt_req_cycle got=%b/%b exp=0001/0", ctl, bus.halted); end
        tick();
        checks++; if (bus.halted !== 1'b1 || ctl !== 4'b0001) begin errors++; $display("FAIL halted got=%b/%b exp=0001/1", ctl, bus.halted); end
        bus.resume = 1;
        tick();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_resume_both got=%b exp=1", bus.halted); end
        bus.halt_req = 0;
        tick();
        bus.resume = 0;
        #1;
        checks++; if (bus.halted !== 1'b0 || ctl !== 4'b1100) begin errors++; $display("FAIL resume got=%b/%b exp=1100/0", ctl, bus.halted); end
        bus.halt_req = 1;
        tick();
        bus.halt_req = 0;
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL rehalt got=%b exp=1", bus.halted); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (bus.halted !== 1'b0 || ctl !== 4'b0011) begin errors++; $display("FAIL reset_in_halt got=%b/%b exp=0011/0", ctl, bus.halted); end
        tick();
        checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL reset_held got=%b exp=0011", ctl); end
        rst_n = 1;
        tick();
        checks++; if (ctl !== 4'b1100 || bus.halted !== 1'b0 || bus.imem_err !== 1'b0) begin
            errors++; $display("FAIL post_reset got=%b/%b/%b exp=1100/0/0", ctl, bus.halted, bus.imem_err);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_redirect_pending();
        test_priority();
        test_timeout();
        test_halt_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum instruction-memory wait in cycles before error.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these inputs:
- id_rs1, id_rs2  in  REG_AW  ID-stage source indices
- id_use1, id_use2  in  1  source actually read
- ex_mem_read  in  1  EX holds a load
- ex_rd  in  REG_AW  EX destination
- ex_redirect  in  1  EX taken branch/jump
- ex_busy  in  1  multi-cycle EX op in progress
- imem_valid  in  1  fetch response for the current PC present this cycle
- halt_req  in  1  debug halt
- resume  in  1  debug resume
REQ-005 The block SHALL have these outputs:
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_bubble  out  1  ID/EX clear to NOP
- halted  out  1  in HALT
- imem_err  out  1  sticky fetch timeout

Function
REQ-006 The block SHALL compute load_use = ex_mem_read & (ex_rd!=0) & ((id_use1 & id_rs1==ex_rd) | (id_use2 & id_rs2==ex_rd)) combinationally.
REQ-007 The FSM SHALL have states RUN, DRAIN and HALT.
REQ-008 In RUN, actions SHALL be decided by the first matching condition, highest priority first:
- ex_redirect: pc_en=1, ifid_flush=1, idex_bubble=1; next state DRAIN if imem_valid=0, else RUN.
- ex_busy: pc_en=0, ifid_en=0, idex_bubble=0 (whole front end frozen).
- load_use: pc_en=0, ifid_en=0, idex_bubble=1.
- !imem_valid: pc_en=0, ifid_flush=1 (bubble into ID).
- halt_req: pc_en=0, ifid_en=0, idex_bubble=1; next state HALT.
- otherwise: pc_en=1, ifid_en=1, all clears 0.
REQ-009 In DRAIN, the block SHALL hold pc_en=0, ifid_flush=1 and discard responses until imem_valid=1; that response is dropped and the next state is RUN with pc_en=1 in that cycle.
REQ-010 In HALT, the block SHALL drive pc_en=0, ifid_en=0, idex_bubble=1 and halted=1; resume=1 SHALL return to RUN on the next edge, with the first RUN cycle behaving per REQ-008.
REQ-011 The outputs ifid_en and ifid_flush SHALL never both be 1; ifid_flush SHALL win whenever both would otherwise be 1.
REQ-012 A wait counter SHALL increment each cycle imem_valid=0 in RUN or DRAIN, clear when imem_valid=1, and saturate at TIMEOUT.
REQ-013 imem_err SHALL set when the wait counter reaches TIMEOUT and SHALL stay set until reset.
REQ-014 halt_req and resume asserted together in HALT SHALL remain in HALT.

Reset
REQ-015 On rst_n low, the block SHALL immediately force: state=RUN, wait counter=0, imem_err=0, pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1 and halted=0.
REQ-016 Reset asserted in DRAIN or HALT SHALL abort the operation with no residual effect after release.

Configuration
REQ-017 With PIPE_CTRL_PERF_EN defined, the block SHALL add 32-bit outputs stall_cnt (cycles with pc_en=0 in RUN) and flush_cnt (ex_redirect events), both wrapping modulo 2^32 and cleared by reset.
REQ-018 Without PIPE_CTRL_PERF_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-019 Bench SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use1=1, imem_valid=1 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1; next cycle with ex_mem_read=0 -> pc_en=1, ifid_en=1.
REQ-020 Bench SHALL cover the x0 case: ex_rd=0, id_rs1=0, id_use1=1 -> no stall.
REQ-021 Bench SHALL cover redirect with fetch pending: ex_redirect=1, imem_valid=0, then imem_valid=0 for 2 cycles and 1 for one cycle -> ifid_flush=1 for all 4 cycles, pc_en=1 in the first and last cycle, then RUN.
REQ-022 Bench SHALL cover priority: ex_redirect=1, ex_busy=1 and load_use=1 in the same cycle -> redirect actions only.
REQ-023 Bench SHALL cover timeout: imem_valid=0 for 16 cycles -> imem_err=1 at cycle 16 and held after imem_valid returns.
REQ-024 Bench SHALL cover halt/reset: halt_req=1 -> halted=1 next cycle; rst_n low mid-HALT -> halted=0 immediately and ifid_flush=1, idex_bubble=1 while rst_n is low.
